// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: next-PC arbitration, instruction-memory latency bubble,
// F/D and D/E stall/flush generation, and saturating stall/flush event counters.
module fetch_sequencer #(
   parameter int              PC_W     = 9,
   parameter int              RA_W     = 4,
   parameter int              CNT_W    = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCSrcE,
   input  logic             PCReturnSignalE,
   input  logic [PC_W-1:0]  PCTargetE,
   input  logic [PC_W-1:0]  PCReturnE,
   input  logic             MemReadE,
   input  logic [RA_W-1:0]  RdE,
   input  logic [RA_W-1:0]  Rs1D,
   input  logic [RA_W-1:0]  Rs2D,
   input  logic             HaltD,
   output logic [PC_W-1:0]  PCF,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic             ValidD,
   output logic             Halted,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic [1:0] {
      S_PREFETCH = 2'd0,
      S_RUN      = 2'd1,
      S_BUBBLE   = 2'd2,
      S_HALT     = 2'd3
   } state_e;

   localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              valid;
   logic              steerable;
   logic              redirect;
   logic              load_use;
   logic              halt_go;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // Decode-stage qualification: hazards and halts only matter for a real instruction.
   always_comb begin
      valid     = (state_q == S_RUN);
      steerable = (state_q == S_RUN) || (state_q == S_BUBBLE);
      redirect  = steerable && (PCReturnSignalE || PCSrcE);
      load_use  = valid && !redirect && MemReadE && (RdE != '0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
      halt_go   = valid && !redirect && !load_use && HaltD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_PREFETCH;
         pc_q        <= RESET_PC;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_PREFETCH: state_d = S_RUN;
         S_RUN, S_BUBBLE: begin
            if (redirect)     state_d = S_BUBBLE;
            else if (halt_go) state_d = S_HALT;
            else              state_d = S_RUN;
         end
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_PREFETCH;
      endcase
   end

   // Next-PC arbitration; return outranks branch, both outrank any hold.
   always_comb begin
      pc_d = pc_q;
      unique case (state_q)
         S_PREFETCH: pc_d = pc_q + PC_ONE;
         S_RUN, S_BUBBLE: begin
            if (PCReturnSignalE)          pc_d = PCReturnE;
            else if (PCSrcE)              pc_d = PCTargetE;
            else if (load_use || halt_go) pc_d = pc_q;
            else                          pc_d = pc_q + PC_ONE;
         end
         default:    pc_d = pc_q;
      endcase
   end

   always_comb begin
      stall_cnt_d = load_use ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = redirect ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      ValidD = 1'b0;
      Halted = 1'b0;
      unique case (state_q)
         S_PREFETCH, S_BUBBLE: begin
            FlushD = 1'b1;
            FlushE = redirect;
         end
         S_RUN: begin
            ValidD = 1'b1;
            StallF = load_use;
            StallD = load_use;
            FlushD = redirect;
            FlushE = redirect || load_use;
         end
         S_HALT: begin
            StallF = 1'b1;
            FlushD = 1'b1;
            Halted = 1'b1;
         end
         default: FlushD = 1'b1;
      endcase
   end

   assign PCF        = pc_q;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule
